// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1:4 demultiplexer.
// DEMUX_STATS_EN (see demux1_4_reg) adds per-output transfer counters.
package demux_pkg;

    localparam int unsigned NUM_OUT = 4;
    localparam int unsigned CNT_W   = 8;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with valid/ready handshake toward a single consumer.
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             drain_rdy,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             can_load
);

    slot_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Load wins over drain: a simultaneous drain+refill keeps the slot full with new data.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_FULL;
                    data_d  = din;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    data_d = din;
                end else if (drain_rdy) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign dout     = data_q;
    assign valid    = (state_q == SLOT_FULL);
    assign can_load = ~valid | drain_rdy;

endmodule

// File: rtl/demux1_4_reg.sv
// Registered 1:4 demultiplexer: routes d to slot s with per-slot valid/ready.
// Define DEMUX_STATS_EN to add saturating per-slot accept counters cnt0..cnt3.
module demux1_4_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  sel_t             s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             v0,
    output logic             v1,
    output logic             v2,
    output logic             v3,
    input  logic             r0,
    input  logic             r1,
    input  logic             r2,
    input  logic             r3
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
`endif
);

    logic [NUM_OUT-1:0] load;
    logic [NUM_OUT-1:0] can_load;
    logic [NUM_OUT-1:0] valid;
    logic [NUM_OUT-1:0] drain_rdy;
    logic [WIDTH-1:0]   dout [NUM_OUT];
    logic               accept;

    assign drain_rdy = {r3, r2, r1, r0};
    assign in_ready  = can_load[s];
    assign accept    = in_valid & in_ready;

    always_comb begin
        load = '0;
        load[s] = accept;
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[k]),
            .din      (d),
            .drain_rdy(drain_rdy[k]),
            .dout     (dout[k]),
            .valid    (valid[k]),
            .can_load (can_load[k])
        );
    end

    assign y0 = dout[0];
    assign y1 = dout[1];
    assign y2 = dout[2];
    assign y3 = dout[3];
    assign v0 = valid[0];
    assign v1 = valid[1];
    assign v2 = valid[2];
    assign v3 = valid[3];

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_OUT];
    logic [CNT_W-1:0] cnt_d [NUM_OUT];

    always_comb begin
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (load[k] && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NUM_OUT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_OUT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux1_4_reg.sv
// Scoreboard bench for demux1_4_reg; expected slot state is queued at drive time
// and compared one cycle later. Counter checks run when DEMUX_STATS_EN is defined.
module tb_demux1_4_reg;

    localparam int W = 1;

    typedef struct {
        logic [3:0]   v;
        logic [4*W-1:0] y;
        logic [31:0]  cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   s = 2'd0;
    logic [W-1:0] d = '0;
    logic [W-1:0] y0, y1, y2, y3;
    logic         v0, v1, v2, v3;
    logic         r0 = 1'b0, r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
`ifdef DEMUX_STATS_EN
    logic [7:0]   cnt0, cnt1, cnt2, cnt3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    exp_t         sb_q [$];
    logic [3:0]   m_v;
    logic [W-1:0] m_y [4];
    int           m_cnt [4];

    demux1_4_reg #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .s       (s),
        .d       (d),
        .y0      (y0),
        .y1      (y1),
        .y2      (y2),
        .y3      (y3),
        .v0      (v0),
        .v1      (v1),
        .v2      (v2),
        .v3      (v3),
        .r0      (r0),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3)
`ifdef DEMUX_STATS_EN
        ,
        .cnt0    (cnt0),
        .cnt1    (cnt1),
        .cnt2    (cnt2),
        .cnt3    (cnt3)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_cnt();
        return {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]};
    endfunction

    task automatic model_reset();
        m_v = '0;
        for (int k = 0; k < 4; k++) begin
            m_y[k] = '0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, "_v"}, {v3, v2, v1, v0}, e.v);
        check({tag, "_y"}, {y3, y2, y1, y0}, e.y);
`ifdef DEMUX_STATS_EN
        check({tag, "_cnt"}, {cnt3, cnt2, cnt1, cnt0}, e.cnt);
`endif
    endtask

    // Inputs already driven; settle, check in_ready, queue expected state, clock, compare.
    task automatic step(input string tag);
        logic [3:0] r;
        logic       rdy, acc;
        exp_t       e, got;
        #1;
        r   = {r3, r2, r1, r0};
        rdy = ~m_v[s] | r[s];
        check({tag, "_rdy"}, in_ready, rdy);
        acc = in_valid & rdy;
        for (int k = 0; k < 4; k++) begin
            if (acc && (s == k[1:0])) begin
                m_v[k] = 1'b1;
                m_y[k] = d;
                if (m_cnt[k] < 255) m_cnt[k]++;
            end else if (m_v[k] && r[k]) begin
                m_v[k] = 1'b0;
            end
        end
        e.v   = m_v;
        e.y   = {m_y[3], m_y[2], m_y[1], m_y[0]};
        e.cnt = pack_cnt();
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_outputs(tag, got);
    endtask

    task automatic check_reset_state(input string tag);
        exp_t e;
        model_reset();
        e.v = '0;
        e.y = '0;
        e.cnt = '0;
        check({tag, "_rdy"}, in_ready, 1'b1);
        check_outputs(tag, e);
    endtask

    task automatic drive(input logic iv, input logic [1:0] sel, input logic [W-1:0] dat,
                         input logic [3:0] r);
        in_valid = iv;
        s = sel;
        d = dat;
        {r3, r2, r1, r0} = r;
    endtask

    initial begin
        model_reset();
        #3 rst = 1'b0;
        #1 check_reset_state("reset_async");
        #8 rst = 1'b1;
        @(posedge clk);
        #1;

        drive(1'b1, 2'd2, 1'b1, 4'b0000); step("t2_load_s2");
        drive(1'b1, 2'd2, 1'b0, 4'b0000); step("t3_s2_blocked");
        drive(1'b1, 2'd1, 1'b1, 4'b0000); step("t3_s1_load");
        drive(1'b1, 2'd3, 1'b0, 4'b0000); step("t4_fill_s3");
        drive(1'b1, 2'd3, 1'b1, 4'b1000); step("t4_drain_refill");
        drive(1'b1, 2'd0, 1'b1, 4'b0000); step("t5_fill_s0");
        drive(1'b0, 2'd1, 1'b0, 4'b1111); step("t5_drain_all");
        drive(1'b0, 2'd0, 1'b1, 4'b0000); step("idle_ignored");

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  W'($urandom), 4'($urandom));
            step("rand");
        end

        drive(1'b1, 2'd0, 1'b1, 4'b0000); step("pre_reset_fill");
        #2 rst = 1'b0;
        #1 check_reset_state("reset_mid");
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd0, W'(i), 4'b0001);
            step("stats_s0");
        end
        drive(1'b0, 2'd0, 1'b0, 4'b1111); step("stats_final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
